decoder_xx6812: RTL and testbench
=================================

# decoder_xx6812

Receives the single-wire WS2812/SK6812 (xx6812) serial stream and recovers 24-bit LED words, the inverse of `encoder_xx6812`. It sits on the strip input of a downstream actor board, or in loopback benches behind the encoder. It measures high-pulse widths on the oversampled `clock_12mhz` domain, shifts bits MSB first, and flags word boundaries, latch gaps and protocol errors.

## Interface
- `BITS`, 24, bits per word
- `BIT_THRESHOLD`, 8, high-pulse length in cycles at or above which a bit decodes as 1 (0-bit ≈5, 1-bit ≈10 at 12 MHz)
- `MIN_HIGH`, 2, shortest legal high pulse; shorter is a glitch
- `MAX_HIGH`, 20, high pulse reaching this length is an error
- `LATCH_CYCLES`, 600, consecutive low cycles that form a latch/reset gap (50 µs)

Ports:
- `clock`, input, 1, sampling clock (`clock_12mhz`)
- `reset`, input, 1, asynchronous, active-low
- `serial_data_in`, input, 1, strip data line, asynchronous to `clock`
- `parallel_data_out`, output, 24, last completed word, MSB = first bit received
- `data_valid`, output, 1, one-cycle pulse when `parallel_data_out` updates
- `frame_start`, output, 1, one-cycle pulse coincident with `data_valid` for the first word after a latch
- `latch`, output, 1, one-cycle pulse when a latch gap completes
- `error`, output, 1, one-cycle pulse on any protocol violation
- `word_index`, output, 8, index of the word on `parallel_data_out` since the last latch (0-based, saturates at 255)

## Operation
- Input path: two-flop synchronizer (s1, s2) plus a delay flop s3. Rising edge = s2 & !s3; falling edge = !s2 & s3.
- Counters: `low_count` and `high_count`, sized for `LATCH_CYCLES` and `MAX_HIGH`, both saturating. `bit_count` is 0..BITS-1. The shift register is BITS wide.
- SYNC (reset state): wait for s2 low for `LATCH_CYCLES` consecutive cycles; any high sample clears `low_count`. On reaching the count, go to LOW with the latch-seen flag set. No `latch` pulse is issued from SYNC.
- LOW: increment `low_count`.
  - When `low_count` reaches `LATCH_CYCLES` for the first time in this low period:
    - pulse `latch`;
    - if `bit_count` ≠ 0, also pulse `error` and discard the partial word;
    - clear `bit_count`, clear `word_index`, set the frame-start flag.
  - On a rising edge: clear `high_count` and `low_count`, go to HIGH.
- HIGH: increment `high_count`.
  - If `high_count` reaches `MAX_HIGH`: pulse `error`, clear `bit_count`, go to SYNC.
  - On a falling edge with `high_count` < `MIN_HIGH`: pulse `error`, clear `bit_count`, go to SYNC.
  - On any other falling edge: shift in `high_count` ≥ `BIT_THRESHOLD`, increment `bit_count`, go to LOW.
  - When the shifted bit is bit BITS-1:
    - load `parallel_data_out`, pulse `data_valid`, set `bit_count` to 0;
    - drive `word_index` with the current word count, then increment it (saturating);
    - pulse `frame_start` if the frame-start flag is set, then clear the flag.
- Data between latches is treated as a continuous word stream. No limit on words per frame.

## Timing
- Reset values: `parallel_data_out` = 0, `data_valid` = `frame_start` = `latch` = `error` = 0, `word_index` = 0, state = SYNC, all counters 0, synchronizer flops 0.
- Assertion of `reset` mid-word or mid-frame returns everything to those values immediately. The decoder must see a full latch gap before it decodes again.
- Latency: an input edge sampled at rising edge k reaches s2 at k+1. The FSM acts and registers outputs at k+2.
  - `data_valid` is high for exactly the cycle after edge k+2, where k samples the falling edge of the 24th bit.
  - `latch` rises at the edge where `low_count` hits `LATCH_CYCLES`, measured from s2 going low.
- `high_count` equals the synchronized high width in cycles, ±1 cycle of quantisation versus `serial_data_in`.
- Outputs are registered. `parallel_data_out` holds its value until the next completed word.
- `latch` and `error` may pulse in the same cycle (partial word at gap). `data_valid` and `latch` never coincide.

## Test plan
- Release reset with the line low for 600 cycles, then send 24 bits of 0x808080 (1-bits high 10 / low 5 cycles, 0-bits high 5 / low 10) -> exactly one `data_valid`, `parallel_data_out` = 0x808080, `frame_start` = 1, `word_index` = 0, no `error`.
- Three back-to-back words 0xFFFFFF, 0x000000, 0xA5C33C, then line low for 700 cycles -> three `data_valid` pulses with those values and `word_index` 0, 1, 2; one `latch` pulse about 600 cycles after the last falling edge; no `error`.
- Send 10 bits, then idle low for 600 cycles -> `latch` and `error` pulse together, no `data_valid`. A following full word decodes correctly with `frame_start` = 1.
- A 1-cycle high glitch mid-word -> `error` pulse, state SYNC. Words sent with less than a 600-cycle low gap are ignored. After a gap, decoding resumes.
- Hold the line high for 25 cycles -> `error` at `high_count` = 20. No output until the line has been low for 600 cycles.
- Assert `reset` after 12 bits of a word, release it, then send a gap and 0x123456 -> all outputs 0 during reset, then a single `data_valid` with 0x123456.
- Loopback against `encoder_xx6812` driven by 0x808080 -> decoded word equals 0x808080 every frame.

Source files
------------

// File: rtl/decoder_xx6812.sv
// -----------------------------------------------------------------------------
// decoder_xx6812
//
// Recovers 24-bit LED words from a single-wire WS2812/SK6812 serial stream by
// measuring high-pulse widths on the oversampling clock. Bits are shifted in
// MSB first. Word boundaries, latch (reset) gaps and protocol violations are
// reported as one-cycle pulses.
//
// Ports:
//   clock             in   sampling clock (12 MHz oversampling domain)
//   reset             in   asynchronous, active-low
//   serial_data_in    in   strip data line, asynchronous to clock
//   parallel_data_out out  last completed word, MSB = first bit received
//   data_valid        out  one-cycle pulse when parallel_data_out updates
//   frame_start       out  pulse with data_valid for the first word after a latch
//   latch             out  one-cycle pulse when a latch gap completes
//   error             out  one-cycle pulse on any protocol violation
//   word_index        out  index of the word on parallel_data_out since the
//                          last latch (0-based, saturates at 255)
// -----------------------------------------------------------------------------
module decoder_xx6812 #(
    parameter int BITS          = 24,
    parameter int BIT_THRESHOLD = 8,
    parameter int MIN_HIGH      = 2,
    parameter int MAX_HIGH      = 20,
    parameter int LATCH_CYCLES  = 600
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            serial_data_in,
    output logic [BITS-1:0] parallel_data_out,
    output logic            data_valid,
    output logic            frame_start,
    output logic            latch,
    output logic            error,
    output logic [7:0]      word_index
);

    localparam int LOW_W  = $clog2(LATCH_CYCLES + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 1);
    localparam int BIT_W  = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(LATCH_CYCLES);
    localparam logic [LOW_W-1:0]  LOW_LAST = LOW_W'(LATCH_CYCLES - 1);
    localparam logic [LOW_W-1:0]  LOW_ONE  = LOW_W'(1);
    localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_MIN = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(1);
    localparam logic [HIGH_W-1:0] HIGH_THR = HIGH_W'(BIT_THRESHOLD);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LOW,
        ST_HIGH
    } state_t;

    // Saturating increments
    function automatic logic [LOW_W-1:0] inc_low(input logic [LOW_W-1:0] v);
        return (v == LOW_MAX) ? v : v + LOW_ONE;
    endfunction

    function automatic logic [HIGH_W-1:0] inc_high(input logic [HIGH_W-1:0] v);
        return (v == HIGH_MAX) ? v : v + HIGH_ONE;
    endfunction

    function automatic logic [7:0] inc_word(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchronizer (s1, s2) and edge-detect delay flop (s3)
    logic s1, s2, s3;
    logic rise, fall;

    state_t            state, state_nxt;
    logic [LOW_W-1:0]  low_count, low_nxt;
    logic [HIGH_W-1:0] high_count, high_nxt, high_inc;
    logic [BIT_W-1:0]  bit_count, bit_nxt;
    logic [BITS-1:0]   shift_reg, shift_nxt, shifted;
    logic [7:0]        word_count, word_count_nxt;
    logic              frame_pending, frame_pending_nxt;
    logic              bit_val;

    logic [BITS-1:0]   pdo_nxt;
    logic              dv_nxt, fs_nxt, latch_nxt, error_nxt;
    logic [7:0]        widx_nxt;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign bit_val  = (high_count >= HIGH_THR);
    assign shifted  = {shift_reg[BITS-2:0], bit_val};
    assign high_inc = inc_high(high_count);

    always_comb begin
        state_nxt         = state;
        low_nxt           = low_count;
        high_nxt          = high_count;
        bit_nxt           = bit_count;
        shift_nxt         = shift_reg;
        word_count_nxt    = word_count;
        frame_pending_nxt = frame_pending;
        pdo_nxt           = parallel_data_out;
        widx_nxt          = word_index;
        dv_nxt            = 1'b0;
        fs_nxt            = 1'b0;
        latch_nxt         = 1'b0;
        error_nxt         = 1'b0;

        case (state)
            ST_SYNC: begin
                // Only a full quiet gap re-arms decoding; no latch pulse here.
                if (s2) begin
                    low_nxt = '0;
                end else begin
                    low_nxt = inc_low(low_count);
                    if (low_nxt == LOW_MAX) begin
                        state_nxt         = ST_LOW;
                        frame_pending_nxt = 1'b1;
                        bit_nxt           = '0;
                        word_count_nxt    = '0;
                    end
                end
            end

            ST_LOW: begin
                if (rise) begin
                    high_nxt  = '0;
                    low_nxt   = '0;
                    state_nxt = ST_HIGH;
                end else begin
                    low_nxt = inc_low(low_count);
                    // low_count saturates at LATCH_CYCLES, so this fires once
                    // per low period (and never right after leaving SYNC).
                    if (low_count == LOW_LAST) begin
                        latch_nxt         = 1'b1;
                        error_nxt         = (bit_count != '0);
                        bit_nxt           = '0;
                        word_count_nxt    = '0;
                        widx_nxt          = '0;
                        frame_pending_nxt = 1'b1;
                    end
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    if (high_count < HIGH_MIN) begin
                        error_nxt = 1'b1;
                        bit_nxt   = '0;
                        low_nxt   = '0;
                        state_nxt = ST_SYNC;
                    end else begin
                        shift_nxt = shifted;
                        // The falling-edge cycle is the first low cycle.
                        low_nxt   = LOW_ONE;
                        state_nxt = ST_LOW;
                        if (bit_count == BIT_LAST) begin
                            pdo_nxt           = shifted;
                            dv_nxt            = 1'b1;
                            bit_nxt           = '0;
                            widx_nxt          = word_count;
                            word_count_nxt    = inc_word(word_count);
                            fs_nxt            = frame_pending;
                            frame_pending_nxt = 1'b0;
                        end else begin
                            bit_nxt = bit_count + BIT_ONE;
                        end
                    end
                end else begin
                    high_nxt = high_inc;
                    if (high_inc == HIGH_MAX) begin
                        error_nxt = 1'b1;
                        bit_nxt   = '0;
                        low_nxt   = '0;
                        state_nxt = ST_SYNC;
                    end
                end
            end

            default: begin
                state_nxt = ST_SYNC;
                low_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1                <= 1'b0;
            s2                <= 1'b0;
            s3                <= 1'b0;
            state             <= ST_SYNC;
            low_count         <= '0;
            high_count        <= '0;
            bit_count         <= '0;
            shift_reg         <= '0;
            word_count        <= '0;
            frame_pending     <= 1'b0;
            parallel_data_out <= '0;
            data_valid        <= 1'b0;
            frame_start       <= 1'b0;
            latch             <= 1'b0;
            error             <= 1'b0;
            word_index        <= '0;
        end else begin
            s1                <= serial_data_in;
            s2                <= s1;
            s3                <= s2;
            state             <= state_nxt;
            low_count         <= low_nxt;
            high_count        <= high_nxt;
            bit_count         <= bit_nxt;
            shift_reg         <= shift_nxt;
            word_count        <= word_count_nxt;
            frame_pending     <= frame_pending_nxt;
            parallel_data_out <= pdo_nxt;
            data_valid        <= dv_nxt;
            frame_start       <= fs_nxt;
            latch             <= latch_nxt;
            error             <= error_nxt;
            word_index        <= widx_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_xx6812.sv
// -----------------------------------------------------------------------------
// tb_decoder_xx6812
//
// Bench for decoder_xx6812. Words are driven as WS2812 waveforms (1-bit: high
// 10 / low 5 cycles, 0-bit: high 5 / low 10 cycles); each word expected to
// decode is queued and compared when data_valid appears. Latch and error
// pulses are counted and checked per scenario.
// -----------------------------------------------------------------------------
module tb_decoder_xx6812;

    logic        clock;
    logic        reset;
    logic        sdi;
    logic [23:0] pdo;
    logic        dv, fs, lat, err;
    logic [7:0]  widx;

    decoder_xx6812 dut (
        .clock             (clock),
        .reset             (reset),
        .serial_data_in    (sdi),
        .parallel_data_out (pdo),
        .data_valid        (dv),
        .frame_start       (fs),
        .latch             (lat),
        .error             (err),
        .word_index        (widx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] data;
        logic        fs;
        logic [7:0]  idx;
    } exp_t;

    typedef struct {
        int          gap;
        logic [23:0] word;
        logic        fs;
        logic [7:0]  idx;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int last_rise_cyc = 0;
    int last_latch_cyc = 0;
    int last_err_cyc = 0;
    int dv_cnt = 0, latch_cnt = 0, err_cnt = 0, both_cnt = 0;
    int d0, l0, e0, b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [23:0] d, input logic f, input logic [7:0] i);
        exp_t e;
        e.data = d;
        e.fs   = f;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        sdi = 1'b1;
        last_rise_cyc = cyc;
        repeat (b ? 10 : 5) @(negedge clock);
        sdi = 1'b0;
        last_fall_cyc = cyc;
        repeat (b ? 5 : 10) @(negedge clock);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        sdi = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pdo"},   {8'h0, pdo}, 32'h0);
        check({tag, "_dv"},    {31'h0, dv}, 32'h0);
        check({tag, "_fs"},    {31'h0, fs}, 32'h0);
        check({tag, "_latch"}, {31'h0, lat}, 32'h0);
        check({tag, "_error"}, {31'h0, err}, 32'h0);
        check({tag, "_widx"},  {24'h0, widx}, 32'h0);
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (dv === 1'b1) begin
                dv_cnt++;
                check("dv_latch_overlap", {31'h0, lat}, 32'h0);
                if (sb.size() == 0) begin
                    check("dv_unexpected", 32'h1, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_data", {8'h0, pdo}, {8'h0, mon_e.data});
                    check("frame_start", {31'h0, fs}, {31'h0, mon_e.fs});
                    check("word_index", {24'h0, widx}, {24'h0, mon_e.idx});
                    check("dv_latency", cyc - last_fall_cyc, 32'd3);
                end
            end else if (fs === 1'b1) begin
                check("fs_without_dv", 32'h1, 32'h0);
            end
            if (lat === 1'b1) begin
                latch_cnt++;
                last_latch_cyc = cyc;
            end
            if (err === 1'b1) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (lat === 1'b1 && err === 1'b1) both_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [9:0]  partial;
        logic [23:0] w;

        vt[0] = '{620, 24'h808080, 1'b1, 8'd0};
        vt[1] = '{700, 24'hFFFFFF, 1'b1, 8'd0};
        vt[2] = '{0,   24'h000000, 1'b0, 8'd1};
        vt[3] = '{0,   24'hA5C33C, 1'b0, 8'd2};

        // Reset state
        reset = 1'b0;
        sdi   = 1'b0;
        repeat (4) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Table-driven words: first word after reset, then a 3-word frame
        for (int i = 0; i < 4; i++) begin
            idle(vt[i].gap);
            push_exp(vt[i].word, vt[i].fs, vt[i].idx);
            send_word(vt[i].word);
        end
        idle(700);
        check("table_dv_count", dv_cnt, 32'd4);
        check("table_latch_count", latch_cnt, 32'd2);
        check("table_error_count", err_cnt, 32'd0);
        check("latch_timing", last_latch_cyc - last_fall_cyc, 32'd602);
        check("pdo_hold", {8'h0, pdo}, 32'hA5C33C);

        // Partial word followed by a latch gap
        d0 = dv_cnt; l0 = latch_cnt; e0 = err_cnt; b0 = both_cnt;
        partial = 10'b1011001110;
        for (int i = 9; i >= 0; i--) send_bit(partial[i]);
        idle(650);
        check("partial_latch", latch_cnt - l0, 32'd1);
        check("partial_error", err_cnt - e0, 32'd1);
        check("partial_coincide", both_cnt - b0, 32'd1);
        check("partial_no_dv", dv_cnt - d0, 32'd0);
        check("partial_latch_timing", last_latch_cyc - last_fall_cyc, 32'd602);
        push_exp(24'h5A5A5A, 1'b1, 8'd0);
        send_word(24'h5A5A5A);

        // One-cycle glitch mid-word, ignored word, then resync
        idle(20);
        d0 = dv_cnt; l0 = latch_cnt; e0 = err_cnt;
        w = 24'hC3C3C3;
        for (int i = 23; i >= 19; i--) send_bit(w[i]);
        sdi = 1'b1;
        @(negedge clock);
        sdi = 1'b0;
        repeat (10) @(negedge clock);
        check("glitch_error", err_cnt - e0, 32'd1);
        send_word(24'h111111);
        idle(20);
        check("glitch_ignored_dv", dv_cnt - d0, 32'd0);
        check("glitch_single_error", err_cnt - e0, 32'd1);
        idle(650);
        check("sync_no_latch", latch_cnt - l0, 32'd0);
        push_exp(24'h0F0F0F, 1'b1, 8'd0);
        send_word(24'h0F0F0F);

        // Line held high too long
        d0 = dv_cnt; e0 = err_cnt;
        sdi = 1'b1;
        last_rise_cyc = cyc;
        repeat (25) @(negedge clock);
        sdi = 1'b0;
        repeat (10) @(negedge clock);
        check("max_high_error", err_cnt - e0, 32'd1);
        check("max_high_timing", last_err_cyc - last_rise_cyc, 32'd23);
        send_word(24'h222222);
        idle(20);
        check("max_high_ignored_dv", dv_cnt - d0, 32'd0);
        idle(650);
        push_exp(24'h333333, 1'b1, 8'd0);
        send_word(24'h333333);

        // Reset in the middle of a word
        idle(20);
        w = 24'h123456;
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        reset = 1'b0;
        sdi   = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b1;
        d0 = dv_cnt;
        idle(650);
        push_exp(24'h123456, 1'b1, 8'd0);
        send_word(24'h123456);
        idle(10);
        check("midreset_single_dv", dv_cnt - d0, 32'd1);

        // Repeated encoder-style frames of 0x808080
        l0 = latch_cnt; e0 = err_cnt;
        for (int f = 0; f < 3; f++) begin
            idle(650);
            push_exp(24'h808080, 1'b1, 8'd0);
            send_word(24'h808080);
        end
        idle(20);
        check("frames_latch_count", latch_cnt - l0, 32'd3);
        check("frames_error_count", err_cnt - e0, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
